// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter placing the load/store unit (port 0) and the debug/DMA master (port 1)
// in front of a single-port byte-strobed data memory with a one-cycle registered read.
module data_mem_arbiter #(
   parameter int ADDR_WIDTH    = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int ERR_CNT_WIDTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,

   input  logic                     m0_req_valid_i,
   output logic                     m0_req_ready_o,
   input  logic [DATA_WIDTH/8-1:0]  m0_req_we_i,
   input  logic [ADDR_WIDTH-1:0]    m0_req_addr_i,
   input  logic [DATA_WIDTH-1:0]    m0_req_wdata_i,
   output logic                     m0_rsp_valid_o,
   output logic [DATA_WIDTH-1:0]    m0_rsp_rdata_o,
   output logic                     m0_rsp_err_o,

   input  logic                     m1_req_valid_i,
   output logic                     m1_req_ready_o,
   input  logic [DATA_WIDTH/8-1:0]  m1_req_we_i,
   input  logic [ADDR_WIDTH-1:0]    m1_req_addr_i,
   input  logic [DATA_WIDTH-1:0]    m1_req_wdata_i,
   output logic                     m1_rsp_valid_o,
   output logic [DATA_WIDTH-1:0]    m1_rsp_rdata_o,
   output logic                     m1_rsp_err_o,

   output logic                     mem_en_o,
   output logic [DATA_WIDTH/8-1:0]  mem_we_o,
   output logic [ADDR_WIDTH-1:0]    mem_addr_o,
   output logic [DATA_WIDTH-1:0]    mem_wdata_o,
   input  logic [DATA_WIDTH-1:0]    mem_rdata_i,

   output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_P0   = 2'd1,
      OWN_P1   = 2'd2
   } owner_e;

   logic                     rr_last_q;
   logic                     rsp_valid0_q;
   logic                     rsp_valid1_q;
   logic                     rsp_err0_q;
   logic                     rsp_err1_q;
   owner_e                   rd_owner_q;
   logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

   logic                     grant0;
   logic                     grant1;
   logic                     accept;
   logic                     sel1;
   logic [STRB_WIDTH-1:0]    sel_we;
   logic [ADDR_WIDTH-1:0]    sel_addr;
   logic [DATA_WIDTH-1:0]    sel_wdata;
   logic                     legal;
   logic                     issue;
   owner_e                   rd_owner_d;
   logic [ERR_CNT_WIDTH-1:0] err_cnt_d;

   // Only whole words, aligned halfwords and single bytes are supported by the memory.
   function automatic logic is_legal(input logic [STRB_WIDTH-1:0] we, input logic [1:0] lsb);
      logic ok;
      ok = 1'b0;
      if (we == STRB_WIDTH'(4'b0000) || we == STRB_WIDTH'(4'b1111)) begin
         ok = (lsb == 2'b00);
      end else if (we == STRB_WIDTH'(4'b0011)) begin
         ok = (lsb[0] == 1'b0);
      end else if (we == STRB_WIDTH'(4'b0001)) begin
         ok = 1'b1;
      end
      return ok;
   endfunction

   // rr_last_q = 1 means port 1 won last, so port 0 takes the next contended cycle.
   assign grant0 = m0_req_valid_i & (~m1_req_valid_i | rr_last_q);
   assign grant1 = m1_req_valid_i & (~m0_req_valid_i | ~rr_last_q);

   assign m0_req_ready_o = grant0 & ~rst_i;
   assign m1_req_ready_o = grant1 & ~rst_i;

   assign accept    = m0_req_ready_o | m1_req_ready_o;
   assign sel1      = m1_req_ready_o;
   assign sel_we    = sel1 ? m1_req_we_i    : m0_req_we_i;
   assign sel_addr  = sel1 ? m1_req_addr_i  : m0_req_addr_i;
   assign sel_wdata = sel1 ? m1_req_wdata_i : m0_req_wdata_i;
   assign legal     = is_legal(sel_we, sel_addr[1:0]);
   assign issue     = accept & legal;

   assign mem_en_o    = issue;
   assign mem_we_o    = issue ? sel_we    : '0;
   assign mem_addr_o  = issue ? sel_addr  : '0;
   assign mem_wdata_o = issue ? sel_wdata : '0;

   always_comb begin
      rd_owner_d = OWN_NONE;
      if (issue && sel_we == '0) begin
         rd_owner_d = sel1 ? OWN_P1 : OWN_P0;
      end
      err_cnt_d = err_cnt_q;
      if (accept && !legal && err_cnt_q != '1) begin
         err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_last_q    <= 1'b1;
         rsp_valid0_q <= 1'b0;
         rsp_valid1_q <= 1'b0;
         rsp_err0_q   <= 1'b0;
         rsp_err1_q   <= 1'b0;
         rd_owner_q   <= OWN_NONE;
         err_cnt_q    <= '0;
      end else begin
         rsp_valid0_q <= m0_req_ready_o;
         rsp_valid1_q <= m1_req_ready_o;
         rsp_err0_q   <= m0_req_ready_o & ~legal;
         rsp_err1_q   <= m1_req_ready_o & ~legal;
         rd_owner_q   <= rd_owner_d;
         err_cnt_q    <= err_cnt_d;
         if (accept) begin
            rr_last_q <= sel1;
         end
      end
   end

   // Memory read data arrives the cycle after issue, which is exactly when the response pulses.
   assign m0_rsp_valid_o = rsp_valid0_q;
   assign m1_rsp_valid_o = rsp_valid1_q;
   assign m0_rsp_err_o   = rsp_err0_q;
   assign m1_rsp_err_o   = rsp_err1_q;
   assign m0_rsp_rdata_o = (rd_owner_q == OWN_P0) ? mem_rdata_i : '0;
   assign m1_rsp_rdata_o = (rd_owner_q == OWN_P1) ? mem_rdata_i : '0;
   assign err_cnt_o      = err_cnt_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: byte-addressed memory model, per-cycle reference model and
// directed scenarios with hand-computed literal results.
module tb_data_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        v0, v1;
   logic [3:0]  we0, we1;
   logic [31:0] a0, a1, d0, d1;
   logic        rdy0, rdy1, rv0, rv1, re0, re1;
   logic [31:0] rd0, rd1;
   logic        men;
   logic [3:0]  mwe;
   logic [31:0] maddr, mwd, mrd;
   logic [7:0]  ecnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ERR_CNT_WIDTH(8)) dut (
      .clk_i(clk), .rst_i(rst),
      .m0_req_valid_i(v0), .m0_req_ready_o(rdy0), .m0_req_we_i(we0), .m0_req_addr_i(a0),
      .m0_req_wdata_i(d0), .m0_rsp_valid_o(rv0), .m0_rsp_rdata_o(rd0), .m0_rsp_err_o(re0),
      .m1_req_valid_i(v1), .m1_req_ready_o(rdy1), .m1_req_we_i(we1), .m1_req_addr_i(a1),
      .m1_req_wdata_i(d1), .m1_rsp_valid_o(rv1), .m1_rsp_rdata_o(rd1), .m1_rsp_err_o(re1),
      .mem_en_o(men), .mem_we_o(mwe), .mem_addr_o(maddr), .mem_wdata_o(mwd),
      .mem_rdata_i(mrd), .err_cnt_o(ecnt)
   );

   // Physical memory: strobe lane i lands at byte address addr+i, registered read of the aligned word.
   logic [7:0] bmem [0:1023];
   int         bidx;
   int         wbase;
   initial begin
      for (int i = 0; i < 1024; i++) bmem[i] = 8'h00;
   end
   always @(posedge clk) begin
      if (men) begin
         for (int i = 0; i < 4; i++) begin
            if (mwe[i]) begin
               bidx = (int'(maddr[9:0]) + i) % 1024;
               bmem[bidx] = mwd[8*i +: 8];
            end
         end
         wbase = int'({maddr[9:2], 2'b00});
         mrd <= {bmem[wbase+3], bmem[wbase+2], bmem[wbase+1], bmem[wbase]};
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   byte unsigned mmem [int];
   int           last_g;
   bit           pend_v [2];
   bit           pend_e [2];
   logic [31:0]  pend_d [2];
   int           exp_cnt;
   int           grant_log [$];

   function automatic bit legal_req(input logic [3:0] we, input logic [31:0] a);
      case (we)
         4'b0000, 4'b1111: return (a % 4) == 0;
         4'b0011:          return (a % 2) == 0;
         4'b0001:          return 1'b1;
         default:          return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] model_word(input logic [31:0] a);
      logic [31:0] w;
      int          k;
      w = '0;
      for (int i = 0; i < 4; i++) begin
         k = int'(a) + i;
         if (mmem.exists(k)) w[8*i +: 8] = mmem[k];
      end
      return w;
   endfunction

   initial begin
      int          g;
      logic [3:0]  w;
      logic [31:0] a, d;
      bit          lg;
      last_g  = 1;
      exp_cnt = 0;
      pend_v  = '{0, 0};
      pend_e  = '{0, 0};
      pend_d  = '{0, 0};
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("rst_ready0", rdy0, 0);
            chk("rst_ready1", rdy1, 0);
            chk("rst_mem_en", men, 0);
            chk("rst_rsp_valid0", rv0, 0);
            chk("rst_rsp_valid1", rv1, 0);
            chk("rst_err_cnt", ecnt, 0);
            last_g  = 1;
            exp_cnt = 0;
            pend_v  = '{0, 0};
            pend_e  = '{0, 0};
         end else begin
            chk("rsp_valid0", rv0, pend_v[0]);
            chk("rsp_valid1", rv1, pend_v[1]);
            chk("rsp_err0", re0, pend_v[0] & pend_e[0]);
            chk("rsp_err1", re1, pend_v[1] & pend_e[1]);
            if (pend_v[0]) chk("rsp_rdata0", rd0, pend_d[0]);
            if (pend_v[1]) chk("rsp_rdata1", rd1, pend_d[1]);
            chk("err_cnt", ecnt, exp_cnt);

            if (v0 && v1)  g = (last_g == 0) ? 1 : 0;
            else if (v0)   g = 0;
            else if (v1)   g = 1;
            else           g = -1;
            chk("ready0", rdy0, g == 0);
            chk("ready1", rdy1, g == 1);

            pend_v = '{0, 0};
            pend_e = '{0, 0};
            if (g >= 0) begin
               w  = (g == 0) ? we0 : we1;
               a  = (g == 0) ? a0  : a1;
               d  = (g == 0) ? d0  : d1;
               lg = legal_req(w, a);
               chk("mem_en", men, lg);
               if (lg) begin
                  chk("mem_we", mwe, w);
                  chk("mem_addr", maddr, a);
                  chk("mem_wdata", mwd, d);
               end
               pend_v[g] = 1;
               pend_e[g] = !lg;
               pend_d[g] = (lg && w == 4'b0000) ? model_word(a) : 32'h0;
               if (lg) begin
                  for (int i = 0; i < 4; i++)
                     if (w[i]) mmem[int'(a) + i] = d[8*i +: 8];
               end else if (exp_cnt < 255) begin
                  exp_cnt++;
               end
               last_g = g;
               grant_log.push_back(g);
            end else begin
               chk("idle_mem_en", men, 0);
               chk("idle_mem_we", mwe, 0);
               chk("idle_mem_addr", maddr, 0);
               chk("idle_mem_wdata", mwd, 0);
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic issue(input int p, input logic [3:0] we, input logic [31:0] a,
                        input logic [31:0] d, output logic en, output logic rv,
                        output logic re, output logic [31:0] rd);
      int n;
      if (p == 0) begin v0 = 1; we0 = we; a0 = a; d0 = d; end
      else        begin v1 = 1; we1 = we; a1 = a; d1 = d; end
      for (n = 0; n < 20; n++) begin
         #1;
         if ((p == 0) ? rdy0 : rdy1) break;
         @(posedge clk);
      end
      chk("ready_wait", n < 20, 1);
      en = men;
      @(posedge clk);
      #1;
      if (p == 0) v0 = 0; else v1 = 0;
      #1;
      rv = (p == 0) ? rv0 : rv1;
      re = (p == 0) ? re0 : re1;
      rd = (p == 0) ? rd0 : rd1;
   endtask

   int exp_order [6] = '{0, 1, 0, 1, 0, 1};

   initial begin
      logic        en, rv, re;
      logic [31:0] rd;
      rst = 1;
      v0 = 0; v1 = 0; we0 = 0; we1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 0;

      // contention from reset: alternating grants starting with port 0
      grant_log.delete();
      v0 = 1; we0 = 4'b0000; a0 = 32'h0;
      v1 = 1; we1 = 4'b0000; a1 = 32'h4;
      repeat (6) @(posedge clk);
      #1;
      v0 = 0; v1 = 0;
      chk("contention_grants", grant_log.size(), 6);
      for (int i = 0; i < 6; i++)
         if (i < grant_log.size()) chk($sformatf("grant_order%0d", i), grant_log[i], exp_order[i]);
      @(posedge clk);
      #1;

      // illegal requests never reach memory
      issue(0, 4'b0101, 32'h0, 32'h1, en, rv, re, rd);
      chk("ill_we0101_en", en, 0);  chk("ill_we0101_err", re, 1);
      issue(1, 4'b1111, 32'h2, 32'h2, en, rv, re, rd);
      chk("ill_word_en", en, 0);    chk("ill_word_err", re, 1);
      issue(0, 4'b0011, 32'h1, 32'h3, en, rv, re, rd);
      chk("ill_half_en", en, 0);    chk("ill_half_err", re, 1);
      issue(1, 4'b0000, 32'h3, 32'h0, en, rv, re, rd);
      chk("ill_read_en", en, 0);    chk("ill_read_err", re, 1);
      chk("err_cnt_4", ecnt, 4);

      // single-port write then read
      issue(0, 4'b1111, 32'h10, 32'hDEADBEEF, en, rv, re, rd);
      chk("wr_rsp_valid", rv, 1);   chk("wr_rsp_err", re, 0);  chk("wr_rsp_rdata", rd, 0);
      issue(0, 4'b0000, 32'h10, 32'h0, en, rv, re, rd);
      chk("rd_rsp_valid", rv, 1);   chk("rd_rdata", rd, 32'hDEADBEEF);

      // partial writes from port 1
      issue(0, 4'b1111, 32'h20, 32'h11223344, en, rv, re, rd);
      issue(1, 4'b0001, 32'h21, 32'h000000AA, en, rv, re, rd);
      chk("byte_wr_en", en, 1);
      issue(1, 4'b0011, 32'h22, 32'h0000BBCC, en, rv, re, rd);
      chk("half_wr_en", en, 1);
      issue(1, 4'b0000, 32'h20, 32'h0, en, rv, re, rd);
      chk("partial_rdata", rd, 32'hBBCCAA44);

      // read-after-write on consecutive cycles
      v0 = 1; we0 = 4'b1111; a0 = 32'h30; d0 = 32'hCAFEF00D;
      @(posedge clk);
      #1;
      we0 = 4'b0000; d0 = 32'h0;
      @(posedge clk);
      #1;
      v0 = 0;
      chk("raw_rsp_valid", rv0, 1);
      chk("raw_rdata", rd0, 32'hCAFEF00D);

      // saturation of the error counter
      v0 = 1; we0 = 4'b0101; a0 = 32'h0;
      repeat (300) @(posedge clk);
      #1;
      v0 = 0;
      #1;
      chk("err_cnt_sat", ecnt, 255);
      issue(1, 4'b0101, 32'h0, 32'h0, en, rv, re, rd);
      chk("err_cnt_hold", ecnt, 255);

      // asynchronous reset right after a read is accepted
      v0 = 1; we0 = 4'b0000; a0 = 32'h10;
      @(posedge clk);
      #1;
      rst = 1;
      #1;
      chk("rstmid_rsp_valid", rv0, 0);
      chk("rstmid_ready0", rdy0, 0);
      chk("rstmid_mem_en", men, 0);
      chk("rstmid_err_cnt", ecnt, 0);
      @(posedge clk);
      #1;
      chk("rstmid_rsp_valid_late", rv0, 0);
      rst = 0;
      grant_log.delete();
      v1 = 1; we1 = 4'b0000; a1 = 32'h4;
      @(posedge clk);
      #1;
      v0 = 0; v1 = 0;
      chk("post_rst_grants", grant_log.size(), 1);
      if (grant_log.size() > 0) chk("post_rst_first_grant", grant_log[0], 0);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
